// File: rtl/fib_arb_pkg.sv
// fib_arb_pkg: shared constants, FSM state encoding and helpers for the
// Fibonacci job arbiter (fib_arbiter, fib_rr_pick, fib_arbiter_if).
// Optional build macro used by fib_arbiter: FIB_ARB_TIMEOUT_EN.
package fib_arb_pkg;

    localparam int NREQ           = 4;   // number of requesters
    localparam int N_W            = 5;   // addition-count width
    localparam int DATA_W         = 17;  // result width
    localparam int N_MAX          = 24;  // largest count the adder accepts
    localparam int TIMEOUT_CYCLES = 63;  // WAIT cycles before giving up
    localparam int ID_W           = 2;   // requester id width
    localparam int CNT_W          = 6;   // timeout counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One-hot strobe for requester id.
    function automatic logic [NREQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/fib_arbiter_if.sv
// fib_arbiter_if: requester and adder signals of the Fibonacci job arbiter.
//   req        requester -> arbiter, one bit per requester
//   req_n      requester -> arbiter, packed 5-bit counts (requester i at [5i+4:5i])
//   resp_valid arbiter -> requester, one-hot one-cycle completion strobe
//   resp_data  arbiter -> requester, result for the strobed requester
//   resp_err   arbiter -> requester, error flag qualified by resp_valid
//   adder_n    arbiter -> adder, addition count
//   adder_go   arbiter -> adder, start level
//   adder_done adder -> arbiter, completion
//   adder_data adder -> arbiter, result valid with adder_done
//   busy       arbiter status, high outside IDLE
// modport slave is the arbiter side, modport master the environment side.
interface fib_arbiter_if;
    import fib_arb_pkg::*;

    logic [NREQ-1:0]     req;
    logic [NREQ*N_W-1:0] req_n;
    logic [NREQ-1:0]     resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;
    logic [N_W-1:0]      adder_n;
    logic                adder_go;
    logic                adder_done;
    logic [DATA_W-1:0]   adder_data;
    logic                busy;

    modport slave (
        input  req, req_n, adder_done, adder_data,
        output resp_valid, resp_data, resp_err, adder_n, adder_go, busy
    );

    modport master (
        output req, req_n, adder_done, adder_data,
        input  resp_valid, resp_data, resp_err, adder_n, adder_go, busy
    );

endinterface

// File: rtl/fib_rr_pick.sv
// fib_rr_pick: combinational round-robin selector.
//   req      in   request vector, bit i = requester i
//   pointer  in   requester with highest priority this round
//   valid    out  any request present
//   grant_id out  first requesting id at or after pointer (wrapping)
module fib_rr_pick
    import fib_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] pointer,
    output logic            valid,
    output logic [ID_W-1:0] grant_id
);

    // Candidate k is the requester k positions after the pointer; the
    // ID_W-bit addition wraps for free because NREQ is a power of two.
    logic [ID_W-1:0] cand_id [NREQ];
    logic [NREQ-1:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_id[gi]  = pointer + ID_W'(gi);
            assign cand_req[gi] = req[cand_id[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest candidate is written last.
    always_comb begin
        valid    = |req;
        grant_id = pointer;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                grant_id = cand_id[k];
            end
        end
    end

endmodule

// File: rtl/fib_arbiter.sv
// fib_arbiter: shares one Fibonacci adder among four requesters.
//   clk    in  system clock, all state on rising edge
//   reset  in  asynchronous active-low reset
//   bus    fib_arbiter_if.slave: req/req_n in, resp_* out, adder_* handshake,
//          busy status
// A job is picked round-robin in IDLE, its id and count are latched, the
// count goes to the adder (ISSUE/WAIT) unless it is out of range, and the
// result is strobed back to the requester for one cycle in RESP.
// Build option: define FIB_ARB_TIMEOUT_EN to abandon a WAIT after
// TIMEOUT_CYCLES cycles without adder_done, reporting resp_err.
module fib_arbiter
    import fib_arb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fib_arbiter_if.slave  bus
);

    logic [N_W-1:0] n_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign n_arr[gi] = bus.req_n[gi*N_W +: N_W];
        end
    endgenerate

    state_t            state_reg;
    logic [ID_W-1:0]   id_reg;
    logic [N_W-1:0]    n_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic [NREQ-1:0]   resp_valid_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic              resp_err_reg;
    logic [N_W-1:0]    adder_n_reg;
    logic              adder_go_reg;
    logic              busy_reg;
`ifdef FIB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]  tmo_cnt_reg;
`endif

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;

    fib_rr_pick u_pick (
        .req      (bus.req),
        .pointer  (ptr_reg),
        .valid    (pick_valid),
        .grant_id (pick_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            id_reg         <= '0;
            n_reg          <= '0;
            ptr_reg        <= '0;
            resp_valid_reg <= '0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            adder_n_reg    <= '0;
            adder_go_reg   <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
            tmo_cnt_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        id_reg    <= pick_id;
                        n_reg     <= n_arr[pick_id];
                        busy_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (n_reg > N_W'(N_MAX)) begin
                        // Out-of-range count never reaches the adder.
                        resp_valid_reg <= id_onehot(id_reg);
                        resp_data_reg  <= '0;
                        resp_err_reg   <= 1'b1;
                        ptr_reg        <= id_reg + ID_W'(1);
                        state_reg      <= RESP;
                    end else begin
                        adder_n_reg  <= n_reg;
                        adder_go_reg <= 1'b1;
                        state_reg    <= WAIT;
`ifdef FIB_ARB_TIMEOUT_EN
                        tmo_cnt_reg  <= '0;
`endif
                    end
                end

                WAIT: begin
                    // A completion in the final timeout cycle still wins.
                    if (bus.adder_done) begin
                        resp_valid_reg <= id_onehot(id_reg);
                        resp_data_reg  <= bus.adder_data;
                        resp_err_reg   <= 1'b0;
                        adder_go_reg   <= 1'b0;
                        ptr_reg        <= id_reg + ID_W'(1);
                        state_reg      <= RESP;
                    end
`ifdef FIB_ARB_TIMEOUT_EN
                    else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_valid_reg <= id_onehot(id_reg);
                        resp_data_reg  <= '0;
                        resp_err_reg   <= 1'b1;
                        adder_go_reg   <= 1'b0;
                        ptr_reg        <= id_reg + ID_W'(1);
                        state_reg      <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    resp_valid_reg <= '0;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end

                default: begin
                    resp_valid_reg <= '0;
                    adder_go_reg   <= 1'b0;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.adder_n    = adder_n_reg;
    assign bus.adder_go   = adder_go_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: self-checking bench for fib_arbiter.
// Expected responses are pushed to a scoreboard queue when a job is issued;
// a monitor pops and compares on every resp_valid. An adder model answers
// adder_go with fib(adder_n) after a fixed or random delay and throws
// stray adder_done pulses while adder_go is low.
// Honours FIB_ARB_TIMEOUT_EN to select the timeout or hold scenario.
module tb_fib_arbiter;
    import fib_arb_pkg::*;

    typedef struct packed {
        logic [3:0]  vld;
        logic [16:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    fib_arbiter_if bus ();

    fib_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   ptr_m = 0;          // model round-robin pointer
    logic [4:0] exp_n;        // count the adder should see for the live job
    logic exp_err;            // live job is out of range
    int   fixed_delay = -1;   // adder delay, -1 = random
    bit   never_mode = 1'b0;  // adder never completes

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endtask

    function automatic int fib(input int n);
        int a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // Drive a request at a negedge while idle, record the expectation and
    // check the fixed issue latency.
    task automatic start_job(input logic [3:0] r, input logic [19:0] nv,
                             input bit mutate, input bit tmo);
        int   id;
        logic [4:0] n;
        exp_t e;
        bus.req   = r;
        bus.req_n = nv;
        id        = rr_model(r, ptr_m);
        n         = nv[id*5 +: 5];
        exp_n     = n;
        exp_err   = (n > 5'd24);
        e.vld     = 4'(1 << id);
        e.err     = exp_err | tmo;
        e.data    = e.err ? 17'd0 : 17'(fib(int'(n)));
        exp_q.push_back(e);
        ptr_m     = (id + 1) % 4;
        @(negedge clk);
        chk("busy_rise", 32'(bus.busy), 32'd1);
        chk("go_low_in_issue", 32'(bus.adder_go), 32'd0);
        if (mutate) begin
            bus.req   = 4'($urandom);
            bus.req_n = 20'($urandom);
        end
        @(negedge clk);
        if (exp_err) chk("range_resp_latency", 32'(bus.resp_valid), 32'(e.vld));
        else         chk("go_latency", 32'(bus.adder_go), 32'd1);
    endtask

    task automatic finish_job(input bit mutate);
        for (int i = 0; i < 600 && bus.busy; i++) begin
            @(negedge clk);
            if (bus.busy && mutate) begin
                bus.req   = 4'($urandom);
                bus.req_n = 20'($urandom);
            end
        end
        chk("job_complete", 32'(bus.busy), 32'd0);
        bus.req = 4'd0;
    endtask

    task automatic run_job(input logic [3:0] r, input logic [19:0] nv, input bit mutate);
        start_job(r, nv, mutate, 1'b0);
        finish_job(mutate);
    endtask

    // Adder model.
    initial begin : adder_model
        logic [4:0] n_seen;
        int d;
        bus.adder_done = 1'b0;
        bus.adder_data = '0;
        forever begin
            @(negedge clk);
            bus.adder_done = 1'b0;
            if (bus.adder_go && !never_mode && reset) begin
                chk("adder_n", 32'(bus.adder_n), 32'(exp_n));
                chk("go_on_range_err", 32'(exp_err), 32'd0);
                n_seen = bus.adder_n;
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 15));
                repeat (d) begin
                    @(negedge clk);
                    chk("adder_n_stable", 32'(bus.adder_n), 32'(n_seen));
                    chk("go_held", 32'(bus.adder_go), 32'd1);
                end
                bus.adder_data = 17'(fib(int'(n_seen)));
                bus.adder_done = 1'b1;
                @(negedge clk);
                bus.adder_done = 1'b0;
                bus.adder_data = 17'($urandom);
                chk("done_resp_latency", 32'(bus.resp_valid != 4'd0), 32'd1);
                chk("go_drop", 32'(bus.adder_go), 32'd0);
            end else if (!bus.adder_go && $urandom_range(0, 7) == 0) begin
                bus.adder_done = 1'b1;
                bus.adder_data = 17'($urandom);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid !== 4'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=%b required=none", bus.resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_valid", 32'(bus.resp_valid), 32'(e.vld));
                    chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                    chk("go_low_in_resp", 32'(bus.adder_go), 32'd0);
                end
                $display("resp valid=%b data=%0d err=%0d", bus.resp_valid, bus.resp_data, bus.resp_err);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t dump;
        bit   hold_ok;
        int   go_cnt;
        reset     = 1'b0;
        bus.req   = 4'd0;
        bus.req_n = 20'd0;
        #2;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_adder_go", 32'(bus.adder_go), 32'd0);
        chk("rst_adder_n", 32'(bus.adder_n), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Contention from pointer 0: grants 0,1,2,3, pointer wraps to 0.
        for (int j = 0; j < 4; j++) run_job(4'b1111, {5'd9, 5'd7, 5'd5, 5'd3}, 1'b0);

        // Single job, adder answers after 12 cycles: fib(10) = 55.
        fixed_delay = 12;
        run_job(4'b0001, 20'd10, 1'b0);
        fixed_delay = -1;

        // Out-of-range count and n=0.
        run_job(4'b0100, {5'd0, 5'd25, 5'd0, 5'd0}, 1'b0);
        run_job(4'b1000, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0);
        run_job(4'b0010, {5'd0, 5'd0, 5'd24, 5'd0}, 1'b0);

        // Randomized jobs, sometimes changing req/req_n while busy.
        for (int j = 0; j < 60; j++) begin
            logic [19:0] nv;
            for (int k = 0; k < 4; k++) begin
                nv[k*5 +: 5] = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(25, 31))
                                                            : 5'($urandom_range(0, 24));
            end
            run_job(4'($urandom_range(1, 15)), nv, 1'($urandom_range(0, 1)));
        end

        never_mode = 1'b1;
`ifdef FIB_ARB_TIMEOUT_EN
        start_job(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b0, 1'b1);
        go_cnt = 1;
        for (int i = 0; i < 100 && bus.adder_go; i++) begin
            @(negedge clk);
            if (bus.adder_go) go_cnt++;
        end
        chk("timeout_cycles", 32'(go_cnt), 32'd63);
        finish_job(1'b0);
        start_job(4'b0100, {5'd0, 5'd6, 5'd0, 5'd0}, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
`else
        start_job(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b0, 1'b0);
        hold_ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (!bus.busy || !bus.adder_go) hold_ok = 1'b0;
        end
        chk("wait_hold_200", 32'(hold_ok), 32'd1);
`endif

        // Reset in the middle of WAIT aborts the job silently.
        #2;
        reset   = 1'b0;
        bus.req = 4'd0;
        #1;
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_resp_data", 32'(bus.resp_data), 32'd0);
        chk("abort_resp_err", 32'(bus.resp_err), 32'd0);
        chk("abort_adder_go", 32'(bus.adder_go), 32'd0);
        chk("abort_adder_n", 32'(bus.adder_n), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        dump  = exp_q.pop_back();
        ptr_m = 0;
        never_mode = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Pointer restarted at 0.
        run_job(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
        run_job(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);

        repeat (30) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
